// File: rtl/lsu_pipe.sv
// rtl/lsu_pipe.sv - handshaked load/store unit: data memory, output registers, synchronised input ports
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_req, o_ready      request handshake; accepted when both are high
//   i_wren              1 = store, 0 = load
//   i_addr              byte address
//   i_funct3            size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   i_stData            right-aligned store data
//   i_ph_in             asynchronous input ports, 32 bits per channel
//   o_rvalid, o_ldData  one-cycle load response and extended load data
//   o_fault             one-cycle pulse for a rejected request
//   o_ph_out            output register channels, 32 bits per channel

module lsu_pipe #(
    parameter int DMEM_AW = 11,
    parameter int NUM_OUT = 6,
    parameter int NUM_IN  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req,
    input  logic                  i_wren,
    input  logic [31:0]           i_addr,
    input  logic [2:0]            i_funct3,
    input  logic [31:0]           i_stData,
    input  logic [NUM_IN*32-1:0]  i_ph_in,
    output logic                  o_ready,
    output logic                  o_rvalid,
    output logic [31:0]           o_ldData,
    output logic                  o_fault,
    output logic [NUM_OUT*32-1:0] o_ph_out
);

    localparam int MEM_IW    = DMEM_AW - 2;
    localparam int MEM_WORDS = 2 ** MEM_IW;
    localparam int OUT_IW    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int IN_IW     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RESP} state_t;
    typedef enum logic [1:0] {T_MEM, T_OUT, T_IN} tgt_t;

    state_t state_q, state_d;

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    logic [19:0] page, out_off, in_off;
    logic        hit_mem, hit_out, hit_in;
    logic        misaligned, illegal_f3, req_fault;
    logic        accept, st_ok, ld_ok;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [OUT_IW-1:0] out_sel;
    logic [IN_IW-1:0]  in_sel;

    assign page    = i_addr[31:12];
    // Pages below a window base wrap to huge offsets, so a single
    // upper-bound compare is enough to test window membership.
    assign out_off = page - 20'h10000;
    assign in_off  = page - 20'h10010;
    assign hit_mem = (i_addr[31:DMEM_AW] == '0);
    assign hit_out = (out_off < 20'(NUM_OUT));
    assign hit_in  = (in_off < 20'(NUM_IN));
    assign out_sel = out_off[OUT_IW-1:0];
    assign in_sel  = in_off[IN_IW-1:0];

    assign misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    assign illegal_f3 = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) ||
                        (i_funct3 == 3'b111) || (i_wren && i_funct3[2]);
    assign req_fault  = illegal_f3 || misaligned ||
                        !(hit_mem || hit_out || hit_in) || (i_wren && hit_in);

    assign o_ready = (state_q != S_LOAD);
    assign accept  = i_req && o_ready && !i_reset;
    assign st_ok   = accept && i_wren && !req_fault;
    assign ld_ok   = accept && !i_wren && !req_fault;

    always_comb begin
        be = 4'b1111;
        case (i_funct3[1:0])
            2'b00:   be = 4'b0001 << i_addr[1:0];
            2'b01:   be = 4'b0011 << i_addr[1:0];
            default: be = 4'b1111;
        endcase
    end

    assign wdata = i_stData << {i_addr[1:0], 3'b000};

    // ---------------------------------------------------------------
    // Data memory: byte-enabled write and registered read, both at
    // the accepting edge. Contents are deliberately not reset.
    // ---------------------------------------------------------------
    logic [31:0]       mem [MEM_WORDS];
    logic [31:0]       mem_rdata;
    logic [MEM_IW-1:0] mem_idx;

    assign mem_idx = i_addr[DMEM_AW-1:2];

    always_ff @(posedge i_clk) begin
        if (st_ok && hit_mem) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (ld_ok) begin
            mem_rdata <= mem[mem_idx];
        end
    end

    // ---------------------------------------------------------------
    // Output registers and input synchronisers
    // ---------------------------------------------------------------
    logic [31:0]          out_q [NUM_OUT];
    logic [31:0]          out_d [NUM_OUT];
    logic [NUM_IN*32-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            out_d[k] = out_q[k];
        end
        if (st_ok && hit_out) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    out_d[out_sel][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end
        sync1_d = i_ph_in;
        sync2_d = sync1_q;
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_ph_out
        assign o_ph_out[32*k +: 32] = out_q[k];
    end

    // ---------------------------------------------------------------
    // Load context, captured on acceptance and consumed in LOAD
    // ---------------------------------------------------------------
    logic [1:0]        off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    tgt_t              tgt_q, tgt_d;
    logic [OUT_IW-1:0] out_idx_q, out_idx_d;
    logic [IN_IW-1:0]  in_idx_q, in_idx_d;

    always_comb begin
        off_d     = off_q;
        f3_d      = f3_q;
        tgt_d     = tgt_q;
        out_idx_d = out_idx_q;
        in_idx_d  = in_idx_q;
        if (ld_ok) begin
            off_d     = i_addr[1:0];
            f3_d      = i_funct3;
            out_idx_d = out_sel;
            in_idx_d  = in_sel;
            if (hit_mem) begin
                tgt_d = T_MEM;
            end else if (hit_out) begin
                tgt_d = T_OUT;
            end else begin
                tgt_d = T_IN;
            end
        end
    end

    // Register and input-port data is sampled in the LOAD cycle itself,
    // so a load sees the synchroniser contents of that cycle.
    logic [31:0] rd_word, lane, ld_ext;

    always_comb begin
        case (tgt_q)
            T_OUT:   rd_word = out_q[out_idx_q];
            T_IN:    rd_word = sync2_q[in_idx_q*32 +: 32];
            default: rd_word = mem_rdata;
        endcase
        lane = rd_word >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_ext = {24'h0, lane[7:0]};
            3'b101:  ld_ext = {16'h0, lane[15:0]};
            default: ld_ext = lane;
        endcase
    end

    // ---------------------------------------------------------------
    // Load FSM and response registers
    // ---------------------------------------------------------------
    logic [31:0] ld_data_q, ld_data_d;
    logic        fault_q, fault_d;

    always_comb begin
        state_d   = state_q;
        ld_data_d = ld_data_q;
        fault_d   = accept && req_fault;
        case (state_q)
            S_IDLE: begin
                if (ld_ok) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d   = S_RESP;
                ld_data_d = ld_ext;
            end
            S_RESP: begin
                state_d = ld_ok ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            ld_data_q <= '0;
            fault_q   <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            off_q     <= '0;
            f3_q      <= '0;
            tgt_q     <= T_MEM;
            out_idx_q <= '0;
            in_idx_q  <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ld_data_q <= ld_data_d;
            fault_q   <= fault_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            off_q     <= off_d;
            f3_q      <= f3_d;
            tgt_q     <= tgt_d;
            out_idx_q <= out_idx_d;
            in_idx_q  <= in_idx_d;
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= out_d[k];
            end
        end
    end

    assign o_rvalid = (state_q == S_RESP);
    assign o_ldData = ld_data_q;
    assign o_fault  = fault_q;

endmodule
